alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 53 +++++
 rtl/alu.sv | 57 +++++
 tb/tb_alu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encodings and default widths.
package alu_pkg;

  // Default operand/result width.
  localparam int ALU_WIDTH = 32;

  // Number of rs2 bits used as the SLL shift amount; upper bits are ignored.
  localparam int SHAMT_W = 5;

  // ctrl encodings.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: selects one of eight operations on rs1/rs2.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] result
);

  alu_op_e          op;
  logic             slt_lt;
  logic             sltu_lt;
  logic [WIDTH-1:0] sll_result;

  assign op      = alu_op_e'(ctrl);
  assign slt_lt  = $signed(rs1) < $signed(rs2);
  assign sltu_lt = rs1 < rs2;

  // Logarithmic left shifter: stage gi shifts by 2**gi when rs2[gi] is set,
  // so only the low SHAMT_W bits of rs2 ever influence the result.
  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_shift
    logic [WIDTH-1:0] stage_in;
    logic [WIDTH-1:0] stage_out;
    if (gi == 0) begin : g_first
      assign stage_in = rs1;
    end else begin : g_rest
      assign stage_in = g_shift[gi-1].stage_out;
    end
    assign stage_out = rs2[gi] ? (stage_in << (1 << gi)) : stage_in;
  end

  assign sll_result = g_shift[SHAMT_W-1].stage_out;

  // Operation select; compare results are zero-extended to full width.
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = rs1 + rs2;
      ALU_SUB:  result = rs1 - rs2;
      ALU_AND:  result = rs1 & rs2;
      ALU_OR:   result = rs1 | rs2;
      ALU_XOR:  result = rs1 ^ rs2;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_lt};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_lt};
      ALU_SLL:  result = sll_result;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, full throughput, result and zero flag
// captured together so z always describes the value currently on rd.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  output logic [WIDTH-1:0] rd,
  output logic             z
);

  logic [WIDTH-1:0] rd_next;
  logic             z_next;
  logic [WIDTH-1:0] rd_reg;
  logic             z_reg;
  logic             valid_reg;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ctrl  (ctrl),
    .rs1   (rs1),
    .rs2   (rs2),
    .result(rd_next)
  );

  // Zero flag derived from the very value about to be registered into rd.
  assign z_next = (rd_next == '0);

  // Output registers: reset wins over a concurrent operation; idle cycles
  // clear out_valid but leave rd/z holding the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_reg    <= '0;
      z_reg     <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        rd_reg <= rd_next;
        z_reg  <= z_next;
      end
    end
  end

  assign rd        = rd_reg;
  assign z         = z_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the registered ALU.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [2:0]   ctrl;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         out_valid;
  logic [W-1:0] rd;
  logic         z;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Model state: what rd/z/out_valid should show after the latest edge.
  logic [W-1:0] m_rd;
  logic         m_z;
  logic         m_valid;

  alu #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .ctrl     (ctrl),
    .rs1      (rs1),
    .rs2      (rs2),
    .out_valid(out_valid),
    .rd       (rd),
    .z        (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_rd;
    logic         exp_z;
  } dir_t;

  dir_t dir_tab[12];

  // Reference arithmetic for each operation.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd6:    return (a < b) ? 32'd1 : 32'd0;
      default: return a << (b % 32);
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn %0d got %h expected %h", tag, txn, got, exp);
    end
  endtask

  // Apply one transaction, clock it, advance the model and compare outputs.
  task automatic run(input logic r, input logic v, input logic [2:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    rst      = r;
    in_valid = v;
    ctrl     = op;
    rs1      = a;
    rs2      = b;
    @(posedge clk);
    #1;
    if (r) begin
      m_rd    = '0;
      m_z     = 1'b1;
      m_valid = 1'b0;
    end else if (v) begin
      m_rd    = ref_alu(op, a, b);
      m_z     = (m_rd == 0);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    txn++;
    $display("txn %0d rst=%0b v=%0b op=%0d a=%h b=%h -> rd=%h z=%0b ov=%0b",
             txn, r, v, op, a, b, rd, z, out_valid);
    check("rd", rd, m_rd);
    check("z", {31'd0, z}, {31'd0, m_z});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_rd    = '0;
    m_z     = 1'b1;
    m_valid = 1'b0;
    rst = 1'b1; in_valid = 1'b0; ctrl = '0; rs1 = '0; rs2 = '0;

    dir_tab[0]  = '{3'd0, 32'd20, 32'd30, 32'd50, 1'b0};
    dir_tab[1]  = '{3'd1, 32'd20, 32'd30, 32'hFFFF_FFF6, 1'b0};
    dir_tab[2]  = '{3'd1, 32'd30, 32'd30, 32'd0, 1'b1};
    dir_tab[3]  = '{3'd2, 32'd20, 32'd30, 32'd20, 1'b0};
    dir_tab[4]  = '{3'd3, 32'd20, 32'd30, 32'd30, 1'b0};
    dir_tab[5]  = '{3'd4, 32'd20, 32'd30, 32'd10, 1'b0};
    dir_tab[6]  = '{3'd5, 32'd20, 32'd30, 32'd1, 1'b0};
    dir_tab[7]  = '{3'd5, 32'h8000_0000, 32'd1, 32'd1, 1'b0};
    dir_tab[8]  = '{3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0};
    dir_tab[9]  = '{3'd6, 32'h8000_0000, 32'd1, 32'd0, 1'b1};
    dir_tab[10] = '{3'd7, 32'd1, 32'h21, 32'd2, 1'b0};
    dir_tab[11] = '{3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1};

    // Reset state, with a valid op present that must be ignored.
    run(1'b1, 1'b0, 3'd0, '0, '0);
    run(1'b1, 1'b1, 3'd0, 32'd3, 32'd4);

    // Directed operations back to back, checked against literal answers too.
    foreach (dir_tab[i]) begin
      run(1'b0, 1'b1, dir_tab[i].op, dir_tab[i].a, dir_tab[i].b);
      check("dir_rd", rd, dir_tab[i].exp_rd);
      check("dir_z", {31'd0, z}, {31'd0, dir_tab[i].exp_z});
      check("dir_valid", {31'd0, out_valid}, 32'd1);
    end

    // Idle cycle: out_valid drops, rd/z hold the previous result.
    run(1'b0, 1'b1, 3'd0, 32'd20, 32'd30);
    run(1'b0, 1'b0, 3'd0, 32'd1, 32'd1);
    check("hold_rd", rd, 32'd50);
    check("hold_valid", {31'd0, out_valid}, 32'd0);

    // Reset alongside a valid ADD: the ADD is dropped.
    run(1'b1, 1'b1, 3'd0, 32'd5, 32'd6);
    check("rstop_rd", rd, 32'd0);
    check("rstop_z", {31'd0, z}, 32'd1);
    check("rstop_valid", {31'd0, out_valid}, 32'd0);

    // First operation after reset releases.
    run(1'b0, 1'b1, 3'd0, 32'd7, 32'd8);
    check("post_rst_rd", rd, 32'd15);

    // Randomized traffic including idle cycles and occasional resets.
    for (int i = 0; i < 200; i++) begin
      run(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
